// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ capture scheduler.
package daq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAYLOAD,
    S_PAD,
    S_WAIT_DONE
  } sched_state_t;

  localparam logic [31:0] START_TOKEN = 32'h0000_0000;
  localparam logic [31:0] PAD_WORD    = 32'hDEAD_BEEF;

  localparam int ERR_STARVE_LSB  = 0;
  localparam int ERR_STARVE_W    = 8;
  localparam int ERR_TIMEOUT_BIT = 8;
  localparam int ERR_SEQ_LSB     = 12;
  localparam int ERR_SEQ_W       = 4;

  function automatic logic [15:0] pack_error_flags(input logic [7:0] starve,
                                                   input logic       timeout,
                                                   input logic [3:0] seq);
    logic [15:0] f;
    f = '0;
    f[ERR_STARVE_LSB +: ERR_STARVE_W] = starve;
    f[ERR_TIMEOUT_BIT]                = timeout;
    f[ERR_SEQ_LSB +: ERR_SEQ_W]       = seq;
    return f;
  endfunction

endpackage

// File: rtl/daq_capture_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int G_W  = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [G_W-1:0]  ptr,
  output logic [G_W-1:0]  grant_idx,
  output logic            grant_valid
);

  int c;

  // Walk from the farthest candidate back toward ptr so the nearest request wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (req[c]) begin
        grant_idx   = G_W'(c);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/daq_capture_scheduler.sv
// Round-robin capture scheduler: grants one channel per packet and feeds the
// packetizer a start token, capture-length samples, and packet side-band status.
//
//   state       | meaning
//   S_IDLE      | waiting for an enabled, valid channel to grant
//   S_START     | presenting the start token for the granted channel
//   S_PAYLOAD   | passing samples straight through from the granted channel
//   S_PAD       | source went quiet too long; filling the packet with PAD_WORD
//   S_WAIT_DONE | packet handed off; holding side-band until pkt_done
module daq_capture_scheduler #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int USER_W       = 8,
  parameter int TS_W         = 32,
  parameter int TIMEOUT      = 1024,
  parameter int STARVE_LIMIT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_enable,
  input  logic [N_CH-1:0]        cfg_chan_en,
  input  logic [7:0]             cfg_capture_len,
  input  logic [N_CH-1:0]        ch_tvalid,
  input  logic [N_CH*DATA_W-1:0] ch_tdata,
  output logic [N_CH-1:0]        ch_tready,
  output logic                   m_tvalid,
  output logic [DATA_W-1:0]      m_tdata,
  output logic [USER_W-1:0]      m_tuser,
  input  logic                   m_tready,
  input  logic                   pkt_done,
  output logic [31:0]            timestamp_latched,
  output logic [7:0]             capture_len_cfg,
  output logic [15:0]            error_flags,
  output logic                   busy
);

  import daq_pkg::*;

  localparam int G_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARVE_LIMIT - 1);

  sched_state_t      state, state_nxt;
  logic [G_W-1:0]    rr_ptr, g;
  logic [8:0]        len, cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [TS_W-1:0]   ts_cnt;
  logic [3:0]        seq;
  logic              timeout_flag;
  logic [7:0]        starve_flags;
  logic [ST_W-1:0]   starve_cnt [N_CH];
  logic [N_CH-1:0]   req, waiting;
  logic [G_W-1:0]    arb_idx;
  logic              arb_valid;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              last_beat;

  assign req       = cfg_enable ? (ch_tvalid & cfg_chan_en) : '0;
  assign src_valid = ch_tvalid[g];
  assign src_data  = ch_tdata[int'(g)*DATA_W +: DATA_W];
  assign last_beat = ((cnt + 9'd1) == len);
  assign busy      = (state != S_IDLE);

  rr_arbiter #(.N_CH(N_CH), .G_W(G_W)) u_rr_arbiter (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tuser   = '0;
    ch_tready = '0;
    case (state)
      S_IDLE: begin
        if (arb_valid) state_nxt = S_START;
      end
      S_START: begin
        m_tvalid = 1'b1;
        m_tdata  = DATA_W'(START_TOKEN);
        m_tuser  = USER_W'(g);
        if (m_tready) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        m_tvalid     = src_valid;
        m_tdata      = src_data;
        m_tuser      = USER_W'(g);
        ch_tready[g] = m_tready;
        if (src_valid && m_tready && last_beat) state_nxt = S_WAIT_DONE;
        else if (!src_valid && (to_cnt == TO_LAST)) state_nxt = S_PAD;
      end
      S_PAD: begin
        m_tvalid = 1'b1;
        m_tdata  = DATA_W'(PAD_WORD);
        m_tuser  = USER_W'(g);
        if (m_tready && last_beat) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (pkt_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      g                 <= '0;
      len               <= '0;
      cnt               <= '0;
      to_cnt            <= '0;
      ts_cnt            <= '0;
      seq               <= '0;
      timeout_flag      <= 1'b0;
      timestamp_latched <= '0;
      capture_len_cfg   <= '0;
      error_flags       <= '0;
    end else begin
      state  <= state_nxt;
      ts_cnt <= ts_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            g               <= arb_idx;
            len             <= (cfg_capture_len == 8'd0) ? 9'd256 : {1'b0, cfg_capture_len};
            capture_len_cfg <= cfg_capture_len;
            rr_ptr          <= (arb_idx == G_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        S_START: begin
          if (m_tready) begin
            timestamp_latched <= 32'(ts_cnt);
            cnt               <= '0;
            to_cnt            <= '0;
          end
        end
        S_PAYLOAD: begin
          // Only an absent source ages the timeout; backpressure does not.
          if (src_valid) begin
            if (m_tready) begin
              cnt    <= cnt + 9'd1;
              to_cnt <= '0;
              if (last_beat) begin
                error_flags <= pack_error_flags(starve_flags, timeout_flag, seq);
                seq         <= seq + 4'd1;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            timeout_flag <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_PAD: begin
          if (m_tready) begin
            cnt <= cnt + 9'd1;
            if (last_beat) begin
              error_flags <= pack_error_flags(starve_flags, timeout_flag, seq);
              seq         <= seq + 4'd1;
            end
          end
        end
        S_WAIT_DONE: begin
          if (pkt_done) timeout_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A channel is waiting when it requests but is neither being granted nor served.
  always_comb begin
    waiting = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (state == S_IDLE) waiting[i] = req[i] && !(arb_valid && (int'(arb_idx) == i));
      else                 waiting[i] = req[i] && (int'(g) != i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_flags <= '0;
      for (int i = 0; i < N_CH; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (waiting[i]) begin
          if (starve_cnt[i] == ST_LAST) starve_flags[i] <= 1'b1;
          else                          starve_cnt[i]   <= starve_cnt[i] + 1'b1;
        end else begin
          starve_cnt[i] <= '0;
        end
        if ((state == S_WAIT_DONE) && pkt_done && (int'(g) == i)) starve_flags[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_daq_capture_scheduler.sv
// Directed self-checking bench for daq_capture_scheduler.
module tb_daq_capture_scheduler;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int USER_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cfg_enable;
  logic [N_CH-1:0]        cfg_chan_en;
  logic [7:0]             cfg_capture_len;
  logic [N_CH-1:0]        ch_tvalid;
  logic [N_CH*DATA_W-1:0] ch_tdata;
  logic [N_CH-1:0]        ch_tready;
  logic                   m_tvalid;
  logic [DATA_W-1:0]      m_tdata;
  logic [USER_W-1:0]      m_tuser;
  logic                   m_tready;
  logic                   pkt_done;
  logic [31:0]            timestamp_latched;
  logic [7:0]             capture_len_cfg;
  logic [15:0]            error_flags;
  logic                   busy;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] tb_ts;
  logic [31:0] exp_ts;

  daq_capture_scheduler #(
    .N_CH(N_CH), .DATA_W(DATA_W), .USER_W(USER_W), .TS_W(32),
    .TIMEOUT(8), .STARVE_LIMIT(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_chan_en(cfg_chan_en),
    .cfg_capture_len(cfg_capture_len), .ch_tvalid(ch_tvalid), .ch_tdata(ch_tdata),
    .ch_tready(ch_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tready(m_tready), .pkt_done(pkt_done), .timestamp_latched(timestamp_latched),
    .capture_len_cfg(capture_len_cfg), .error_flags(error_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference cycle count: zero in reset, +1 on every released clock.
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle and channel gi requesting.
  task automatic do_packet(input int gi, input int nbeats, input logic [31:0] base,
                           input logic [15:0] flags, input logic [7:0] lencfg);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_tvalid", 64'(m_tvalid), 64'd0);
    @(negedge clk); #1;
    chk("start_tvalid", 64'(m_tvalid), 64'd1);
    chk("start_tdata", 64'(m_tdata), 64'd0);
    chk("start_tuser", 64'(m_tuser), 64'(gi));
    chk("start_ready", 64'(ch_tready), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    exp_ts = tb_ts;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      ch_tdata[gi*DATA_W +: DATA_W] = base + 32'(k);
      #1;
      chk("pay_tdata", 64'(m_tdata), 64'(base + 32'(k)));
      chk("pay_ready", 64'(ch_tready), 64'd1 << gi);
    end
    @(negedge clk); #1;
    chk("wait_tvalid", 64'(m_tvalid), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_flags", 64'(error_flags), 64'(flags));
    chk("wait_ts", 64'(timestamp_latched), 64'(exp_ts));
    chk("wait_lencfg", 64'(capture_len_cfg), 64'(lencfg));
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    #1;
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_chan_en = '0; cfg_capture_len = 8'd0;
    ch_tvalid = '0; ch_tdata = '0; m_tready = 1'b0; pkt_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_ready", 64'(ch_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'(error_flags), 64'd0);
    chk("rst_ts", 64'(timestamp_latched), 64'd0);
    chk("rst_lencfg", 64'(capture_len_cfg), 64'd0);

    // ch1 alone, four samples 1..4
    rst_n = 1'b1; cfg_enable = 1'b1; cfg_chan_en = 4'hF; cfg_capture_len = 8'd4;
    m_tready = 1'b1; ch_tvalid = 4'b0010;
    do_packet(1, 4, 32'd1, 16'h0000, 8'd4);

    rst_n = 1'b0; ch_tvalid = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst2_lencfg", 64'(capture_len_cfg), 64'd0);

    // All channels valid: round robin 0,1,2 with rising sequence numbers
    rst_n = 1'b1; ch_tvalid = 4'hF; cfg_capture_len = 8'd2;
    do_packet(0, 2, 32'h1000, 16'h0000, 8'd2);
    do_packet(1, 2, 32'h1100, 16'h1000, 8'd2);
    do_packet(2, 2, 32'h1200, 16'h2000, 8'd2);

    // Length 0 means 256 samples
    ch_tvalid = 4'b0001; cfg_capture_len = 8'd0;
    do_packet(0, 256, 32'hA000_0000, 16'h3000, 8'd0);

    // ch2 stalls after one of three samples -> padded packet
    ch_tvalid = 4'b0100; cfg_capture_len = 8'd3; ch_tdata[2*DATA_W +: DATA_W] = 32'h55;
    #1;
    chk("to_idle_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("to_start_tuser", 64'(m_tuser), 64'd2);
    @(negedge clk); #1;
    chk("to_beat_tdata", 64'(m_tdata), 64'h55);
    chk("to_beat_ready", 64'(ch_tready), 64'h4);
    @(negedge clk);
    ch_tvalid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_idle_tvalid", 64'(m_tvalid), 64'd0);
      @(negedge clk);
    end
    ch_tvalid = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("pad_tvalid", 64'(m_tvalid), 64'd1);
      chk("pad_tdata", 64'(m_tdata), 64'hDEAD_BEEF);
      chk("pad_ready", 64'(ch_tready), 64'd0);
      @(negedge clk);
    end
    ch_tvalid = 4'b0000;
    #1;
    chk("pad_wait_tvalid", 64'(m_tvalid), 64'd0);
    chk("pad_wait_flags", 64'(error_flags), 64'h4100);
    chk("pad_wait_lencfg", 64'(capture_len_cfg), 64'd3);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    #1;
    chk("pad_done_busy", 64'(busy), 64'd0);

    // ch3 with long backpressure: no timeout, stray pkt_done ignored
    ch_tvalid = 4'b1000; cfg_capture_len = 8'd2; ch_tdata[3*DATA_W +: DATA_W] = 32'h3333_0000;
    @(negedge clk); #1;
    chk("bp_start_tuser", 64'(m_tuser), 64'd3);
    @(negedge clk); #1;
    chk("bp_beat0_tdata", 64'(m_tdata), 64'h3333_0000);
    @(negedge clk);
    m_tready = 1'b0; ch_tdata[3*DATA_W +: DATA_W] = 32'h3333_0001;
    #1;
    chk("bp_stall_tvalid", 64'(m_tvalid), 64'd1);
    chk("bp_stall_ready", 64'(ch_tready), 64'd0);
    repeat (1998) @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    #1;
    chk("bp_late_busy", 64'(busy), 64'd1);
    chk("bp_late_tvalid", 64'(m_tvalid), 64'd1);
    chk("bp_late_tdata", 64'(m_tdata), 64'h3333_0001);
    m_tready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(ch_tready), 64'h8);
    @(negedge clk);
    ch_tvalid = 4'b0000;
    #1;
    chk("bp_wait_tvalid", 64'(m_tvalid), 64'd0);
    chk("bp_wait_flags", 64'(error_flags), 64'h5000);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;

    // Reset in the middle of a ch1 payload
    ch_tvalid = 4'b0010; cfg_capture_len = 8'd4; ch_tdata[1*DATA_W +: DATA_W] = 32'h77;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mid_pay_tdata", 64'(m_tdata), 64'h77);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mr_tvalid", 64'(m_tvalid), 64'd0);
    chk("mr_ready", 64'(ch_tready), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_flags", 64'(error_flags), 64'd0);
    chk("mr_ts", 64'(timestamp_latched), 64'd0);
    chk("mr_lencfg", 64'(capture_len_cfg), 64'd0);
    chk("mr_tuser", 64'(m_tuser), 64'd0);
    rst_n = 1'b1; ch_tvalid = 4'b0011; cfg_capture_len = 8'd1;
    do_packet(0, 1, 32'h00C0, 16'h0000, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
